// File: rtl/expr_pkg.sv
// Shared constants and types for the expression-string generator.
package expr_pkg;
    localparam logic [7:0]  CH_0      = 8'h30;
    localparam logic [7:0]  CH_PLUS   = 8'h2B;
    localparam logic [7:0]  CH_STAR   = 8'h2A;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {S_IDLE, S_DIGIT, S_OP, S_BAD_OP} state_t;

    // Fold a random nibble into 0..9 and return its ASCII digit.
    function automatic logic [7:0] digit_char(input logic [3:0] nib);
        logic [3:0] d;
        d = (nib >= 4'd10) ? nib - 4'd10 : nib;
        return CH_0 + {4'd0, d};
    endfunction
endpackage

// File: rtl/lfsr16.sv
// 16-bit right-shifting Galois LFSR; advances only when en is high.
module lfsr16
    import expr_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    output logic [15:0] q
);
    logic [15:0] r_q;

    always_ff @(posedge clk) begin
        if (clr)
            r_q <= SEED;
        else if (en)
            r_q <= {1'b0, r_q[15:1]} ^ (r_q[0] ? LFSR_TAPS : 16'h0000);
    end

    assign q = r_q;
endmodule

// File: rtl/expr_gen.sv
// Emits a pseudo-random "d op d op d" ASCII expression, one char per clock,
// optionally malformed ("+*" pair), and reports the verdict a checker must reach.
module expr_gen
    import expr_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [3:0] n_ops,
    input  logic       inject,
    output logic [7:0] out,
    output logic       valid,
    output logic       last,
    output logic       busy,
    output logic       expect_ok
);
    state_t     r_state, w_next;
    logic [3:0] r_cnt, w_cnt_n;
    logic       r_first, w_first_n;
    logic [7:0] r_out, w_char;
    logic       r_valid, r_last, r_busy, r_expect_ok;
    logic       w_emit, w_last, w_busy_n, w_ok_n;
    logic [15:0] w_lfsr;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk (clk),
        .clr (clr),
        .en  (w_emit),
        .q   (w_lfsr)
    );

    always_comb begin
        w_next    = r_state;
        w_cnt_n   = r_cnt;
        w_first_n = r_first;
        w_char    = 8'h00;
        w_emit    = 1'b0;
        w_last    = 1'b0;
        w_busy_n  = r_busy;
        w_ok_n    = r_expect_ok;
        case (r_state)
            S_IDLE: begin
                // r_busy still high here means the last char is on the wire;
                // refusing start then enforces one idle cycle between strings.
                w_busy_n = 1'b0;
                if (start && !r_busy) begin
                    w_next    = S_DIGIT;
                    w_cnt_n   = (n_ops == 4'd0) ? 4'd1 : n_ops;
                    w_first_n = inject;
                    w_ok_n    = ~inject;
                    w_busy_n  = 1'b1;
                end
            end
            S_DIGIT: begin
                w_emit  = 1'b1;
                w_char  = digit_char(w_lfsr[3:0]);
                w_cnt_n = r_cnt - 4'd1;
                if (r_cnt == 4'd1 && !r_first) begin
                    w_last = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_next = S_OP;
                end
            end
            S_OP: begin
                w_emit = 1'b1;
                if (r_first) begin
                    // Forced "+" opens the malformed pair; with one operand it ends the string.
                    w_char    = CH_PLUS;
                    w_first_n = 1'b0;
                    if (r_cnt == 4'd0) begin
                        w_last = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_next = S_BAD_OP;
                    end
                end else begin
                    w_char = w_lfsr[4] ? CH_STAR : CH_PLUS;
                    w_next = S_DIGIT;
                end
            end
            S_BAD_OP: begin
                w_emit = 1'b1;
                w_char = CH_STAR;
                w_next = S_DIGIT;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_first     <= 1'b0;
            r_out       <= 8'h00;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_expect_ok <= 1'b1;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_n;
            r_first     <= w_first_n;
            r_out       <= w_char;
            r_valid     <= w_emit;
            r_last      <= w_last;
            r_busy      <= w_busy_n;
            r_expect_ok <= w_ok_n;
        end
    end

    assign out       = r_out;
    assign valid     = r_valid;
    assign last      = r_last;
    assign busy      = r_busy;
    assign expect_ok = r_expect_ok;
endmodule

// File: tb/tb_expr_gen.sv
// Directed bench for expr_gen; expected characters derived by hand from the
// LFSR sequence starting at 16'hACE1.
module tb_expr_gen;
    logic       clk = 1'b0;
    logic       clr, start, inject;
    logic [3:0] n_ops;
    logic [7:0] out;
    logic       valid, last, busy, expect_ok;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] ex [0:15];

    expr_gen #(.SEED(16'hACE1)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .n_ops     (n_ops),
        .inject    (inject),
        .out       (out),
        .valid     (valid),
        .last      (last),
        .busy      (busy),
        .expect_ok (expect_ok)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_chk++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Start one expression and compare each emitted character against ex[].
    task automatic run_expr(input string tag, input logic [3:0] n, input logic inj,
                            input int len, input logic [15:0] pulse_mask);
        n_ops  = n;
        inject = inj;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        n_ops  = 4'd0;
        inject = 1'b0;
        chk({tag, " busy_after_start"}, {7'd0, busy}, 8'd1);
        chk({tag, " valid_after_start"}, {7'd0, valid}, 8'd0);
        chk({tag, " expect_ok"}, {7'd0, expect_ok}, {7'd0, ~inj});
        for (int i = 0; i < len; i++) begin
            tick();
            chk($sformatf("%s char%0d", tag, i), out, ex[i]);
            chk($sformatf("%s valid%0d", tag, i), {7'd0, valid}, 8'd1);
            chk($sformatf("%s last%0d", tag, i), {7'd0, last}, {7'd0, (i == len - 1)});
            chk($sformatf("%s busy%0d", tag, i), {7'd0, busy}, 8'd1);
            start = pulse_mask[i];
        end
        tick();
        start = 1'b0;
        chk({tag, " idle_valid"}, {7'd0, valid}, 8'd0);
        chk({tag, " idle_busy"}, {7'd0, busy}, 8'd0);
        chk({tag, " idle_out"}, out, 8'h00);
        chk({tag, " idle_expect_ok"}, {7'd0, expect_ok}, {7'd0, ~inj});
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; inject = 1'b0; n_ops = 4'd0;
        tick();
        tick();
        clr = 1'b0;
        chk("rst out", out, 8'h00);
        chk("rst valid", {7'd0, valid}, 8'd0);
        chk("rst busy", {7'd0, busy}, 8'd0);
        chk("rst last", {7'd0, last}, 8'd0);
        chk("rst expect_ok", {7'd0, expect_ok}, 8'd1);

        // LFSR ACE1: nibble 1 -> "1"
        ex[0] = 8'h31;
        run_expr("n1", 4'd1, 1'b0, 1, 16'h0);

        // E270,7138,389C,1C4E,0E27 -> "0*2+7"
        ex[0] = 8'h30; ex[1] = 8'h2A; ex[2] = 8'h32; ex[3] = 8'h2B; ex[4] = 8'h37;
        run_expr("n3", 4'd3, 1'b0, 5, 16'h0);

        // B313, forced +, *, 6162 -> "3+*2"
        ex[0] = 8'h33; ex[1] = 8'h2B; ex[2] = 8'h2A; ex[3] = 8'h32;
        run_expr("n2inj", 4'd2, 1'b1, 4, 16'h0);

        // 30B1, forced + -> "1+"
        ex[0] = 8'h31; ex[1] = 8'h2B;
        run_expr("n1inj", 4'd1, 1'b1, 2, 16'h0);

        // 562C -> "2", n_ops=0 acts as 1
        ex[0] = 8'h32;
        run_expr("n0", 4'd0, 1'b0, 1, 16'h0);

        // 2B16,158B,BEC5 -> "6+5"; start pulsed on 1st and last char is ignored
        ex[0] = 8'h36; ex[1] = 8'h2B; ex[2] = 8'h35;
        run_expr("busy_start", 4'd2, 1'b0, 3, 16'h0005);

        // n_ops=5 injected, abandoned by clr on 3rd char: EB62 -> "2", "+", "*"
        n_ops = 4'd5; inject = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; n_ops = 4'd0; inject = 1'b0;
        chk("clr expect_ok_low", {7'd0, expect_ok}, 8'd0);
        tick();
        chk("clr char0", out, 8'h32);
        tick();
        chk("clr char1", out, 8'h2B);
        tick();
        chk("clr char2", out, 8'h2A);
        clr = 1'b1;
        start = 1'b1;
        n_ops = 4'd1;
        tick();
        clr = 1'b0;
        start = 1'b0;
        chk("clr valid", {7'd0, valid}, 8'd0);
        chk("clr busy", {7'd0, busy}, 8'd0);
        chk("clr last", {7'd0, last}, 8'd0);
        chk("clr out", out, 8'h00);
        chk("clr expect_ok", {7'd0, expect_ok}, 8'd1);

        // LFSR reloaded with SEED -> "1" again
        ex[0] = 8'h31;
        run_expr("after_clr", 4'd1, 1'b0, 1, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
